// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Groups the fetch-side lookup and the decode-side resolve/update signals of
// the dynamic branch predictor. Signal suffixes are from the predictor's view.
//   master : pipeline side (drives run enable, fetch PC and resolved branches)
//   slave  : predictor side (returns prediction, mispredict flag, statistics)
// Signals:
//   start_i          run enable; low freezes predictor state
//   pc_i             IF fetch PC to look up
//   pred_taken_o     predict taken for pc_i
//   pred_target_o    predicted target for pc_i (0 on a miss)
//   upd_valid_i      ID holds a resolved branch this cycle
//   upd_pc_i         PC of the resolved branch
//   upd_taken_i      actual outcome
//   upd_target_i     actual target
//   upd_pred_taken_i prediction that was used for this branch
//   upd_pred_tgt_i   predicted target that was used for this branch
//   mispredict_o     flush IFID and redirect this cycle
//   branch_cnt_o     saturating count of resolved branches
//   mispred_cnt_o    saturating count of mispredicts
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] pc_i;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic              upd_pred_taken_i;
  logic [ADDR_W-1:0] upd_pred_tgt_i;
  logic              mispredict_o;
  logic [STAT_W-1:0] branch_cnt_o;
  logic [STAT_W-1:0] mispred_cnt_o;

  modport master (
    output start_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_tgt_i,
    input  pred_taken_o, pred_target_o, mispredict_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  start_i, pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, upd_pred_tgt_i,
    output pred_taken_o, pred_target_o, mispredict_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped dynamic branch predictor for the 5-stage pipeline. Each entry
// holds valid, tag, target and a saturating counter. IF looks up the fetch PC
// combinationally; ID feeds resolved branches back to train the table, raise
// the mispredict/flush flag and maintain saturating statistics.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous reset, active-high
//   bp     branch_predictor_if.slave (lookup, update and statistics signals)
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ADDR_W   = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  // Only the MSB set: the weakly-taken value given to fresh allocations.
  localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_MAX ^ (CNT_MAX >> 1'b1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(INIT_CNT);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Prediction table, flops only
  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [CNT_W-1:0]  cnt_q   [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // Lookup path
  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              lk_hit_s;
  logic              pred_taken_s;
  logic [ADDR_W-1:0] pred_target_s;

  // Update path
  logic [IDX_W-1:0]  upd_idx_s;
  logic [TAG_W-1:0]  upd_tag_s;
  logic              upd_hit_s;
  logic              upd_en_s;
  logic              mispredict_s;
  logic              wr_en_s;
  logic [TAG_W-1:0]  ent_tag_d;
  logic [ADDR_W-1:0] ent_tgt_d;
  logic [CNT_W-1:0]  ent_cnt_d;

  assign lk_idx_s  = bp.pc_i[IDX_W+1:2];
  assign lk_tag_s  = bp.pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx_s = bp.upd_pc_i[IDX_W+1:2];
  assign upd_tag_s = bp.upd_pc_i[ADDR_W-1:IDX_W+2];

  // Lookup: reads registered table state, so a same-cycle update is not seen yet
  always_comb begin
    lk_hit_s      = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
    pred_taken_s  = 1'b0;
    pred_target_s = {ADDR_W{1'b0}};
    if (lk_hit_s) begin
      pred_taken_s  = bp.start_i & cnt_q[lk_idx_s][CNT_W-1];
      pred_target_s = tgt_q[lk_idx_s];
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = {ADDR_W{1'b0}};
    end
  end

  // Resolve: mispredict flag, entry next-state and statistics next-state
  always_comb begin
    upd_en_s     = bp.upd_valid_i & bp.start_i;
    upd_hit_s    = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    // Wrong direction, or taken both ways but to a different target
    mispredict_s = upd_en_s &
                   ((bp.upd_taken_i != bp.upd_pred_taken_i) |
                    (bp.upd_taken_i & bp.upd_pred_taken_i &
                     (bp.upd_target_i != bp.upd_pred_tgt_i)));

    wr_en_s   = 1'b0;
    ent_tag_d = tag_q[upd_idx_s];
    ent_tgt_d = tgt_q[upd_idx_s];
    ent_cnt_d = cnt_q[upd_idx_s];

    if (upd_en_s && upd_hit_s) begin
      wr_en_s = 1'b1;
      if (bp.upd_taken_i) begin
        ent_tgt_d = bp.upd_target_i;
        ent_cnt_d = (cnt_q[upd_idx_s] == CNT_MAX) ? CNT_MAX : cnt_q[upd_idx_s] + 1'b1;
      end else begin
        ent_cnt_d = (cnt_q[upd_idx_s] == CNT_ZERO) ? CNT_ZERO : cnt_q[upd_idx_s] - 1'b1;
      end
    end else if (upd_en_s && bp.upd_taken_i) begin
      // Taken miss: overwrite whatever alias occupied the slot
      wr_en_s   = 1'b1;
      ent_tag_d = upd_tag_s;
      ent_tgt_d = bp.upd_target_i;
      ent_cnt_d = CNT_WEAK;
    end else begin
      // Not-taken miss or idle: the table is untouched
      wr_en_s = 1'b0;
    end

    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd_en_s) begin
      if (branch_cnt_q != STAT_MAX) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
      end else begin
        branch_cnt_d = branch_cnt_q;
      end
      if (mispredict_s && (mispred_cnt_q != STAT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + 1'b1;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Table storage: async clear, single write port driven by the resolve logic
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= {TAG_W{1'b0}};
        tgt_q[i]   <= {ADDR_W{1'b0}};
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (wr_en_s) begin
      valid_q[upd_idx_s] <= 1'b1;
      tag_q[upd_idx_s]   <= ent_tag_d;
      tgt_q[upd_idx_s]   <= ent_tgt_d;
      cnt_q[upd_idx_s]   <= ent_cnt_d;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q  <= {STAT_W{1'b0}};
      mispred_cnt_q <= {STAT_W{1'b0}};
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.pred_taken_o  = pred_taken_s;
  assign bp.pred_target_o = pred_target_s;
  assign bp.mispredict_o  = mispredict_s;
  assign bp.branch_cnt_o  = branch_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Drives two predictors (16-bit and 4-bit statistics) with identical stimulus
// and compares every output with a behavioural table model.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int ENT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32), .STAT_W(16)) bpa ();
  branch_predictor_if #(.ADDR_W(32), .STAT_W(4))  bpb ();

  branch_predictor #(.STAT_W(16)) u_dut_a (.clk_i(clk), .rst_i(rst), .bp(bpa));
  branch_predictor #(.STAT_W(4))  u_dut_b (.clk_i(clk), .rst_i(rst), .bp(bpb));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays indexed by (pc/4) mod ENT
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_cnt   [ENT];
  int unsigned m_bc, m_mc, m_bc4, m_mc4;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    int unsigned p = pc;
    return int'((p / 4) % ENT);
  endfunction

  function automatic int unsigned m_tg(input logic [31:0] pc);
    int unsigned p = pc;
    return p / (4 * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
  endfunction

  function automatic bit m_pred(input logic st, input logic [31:0] pc);
    return st && m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_cnt[i] = 1;
    end
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  // One cycle: drive at negedge, check just after, train the model at posedge
  task automatic apply(input logic st, input logic [31:0] pc, input logic uv,
                       input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    bit   exp_mp;
    int   i;
    @(negedge clk);
    bpa.start_i = st;  bpa.pc_i = pc;  bpa.upd_valid_i = uv;  bpa.upd_pc_i = upc;
    bpa.upd_taken_i = tk;  bpa.upd_target_i = tgt;  bpa.upd_pred_taken_i = pt;  bpa.upd_pred_tgt_i = ptgt;
    bpb.start_i = st;  bpb.pc_i = pc;  bpb.upd_valid_i = uv;  bpb.upd_pc_i = upc;
    bpb.upd_taken_i = tk;  bpb.upd_target_i = tgt;  bpb.upd_pred_taken_i = pt;  bpb.upd_pred_tgt_i = ptgt;
    #1;
    exp_mp = uv && st && ((tk != pt) || (tk && pt && (tgt != ptgt)));
    check_eq("pred_taken",  {63'd0, bpa.pred_taken_o}, {63'd0, m_pred(st, pc)});
    check_eq("pred_target", {32'd0, bpa.pred_target_o},
             m_hit(pc) ? {32'd0, m_tgt[m_idx(pc)]} : 64'd0);
    check_eq("mispredict_a", {63'd0, bpa.mispredict_o}, {63'd0, exp_mp});
    check_eq("mispredict_b", {63'd0, bpb.mispredict_o}, {63'd0, exp_mp});
    check_eq("branch_cnt_a",  {48'd0, bpa.branch_cnt_o},  64'(m_bc));
    check_eq("mispred_cnt_a", {48'd0, bpa.mispred_cnt_o}, 64'(m_mc));
    check_eq("branch_cnt_b",  {60'd0, bpb.branch_cnt_o},  64'(m_bc4));
    check_eq("mispred_cnt_b", {60'd0, bpb.mispred_cnt_o}, 64'(m_mc4));
    @(posedge clk);
    if (!rst && uv && st) begin
      i = m_idx(upc);
      if (m_hit(upc)) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1; m_tag[i] = m_tg(upc); m_tgt[i] = tgt; m_cnt[i] = 2;
      end
      m_bc  = (m_bc  < 65535) ? m_bc  + 1 : m_bc;
      m_bc4 = (m_bc4 < 15)    ? m_bc4 + 1 : m_bc4;
      if (exp_mp) begin
        m_mc  = (m_mc  < 65535) ? m_mc  + 1 : m_mc;
        m_mc4 = (m_mc4 < 15)    ? m_mc4 + 1 : m_mc4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] upc, tgt, ptgt;
    logic        uv, st, tk, pt;

    rst = 1'b1;
    bpa.start_i = 1'b1; bpa.pc_i = 32'h40; bpa.upd_valid_i = 1'b0; bpa.upd_pc_i = 32'd0;
    bpa.upd_taken_i = 1'b0; bpa.upd_target_i = 32'd0; bpa.upd_pred_taken_i = 1'b0; bpa.upd_pred_tgt_i = 32'd0;
    bpb.start_i = 1'b1; bpb.pc_i = 32'h40; bpb.upd_valid_i = 1'b0; bpb.upd_pc_i = 32'd0;
    bpb.upd_taken_i = 1'b0; bpb.upd_target_i = 32'd0; bpb.upd_pred_taken_i = 1'b0; bpb.upd_pred_tgt_i = 32'd0;
    m_reset();

    // Reset state
    #12;
    check_eq("rst_pred_taken",  {63'd0, bpa.pred_taken_o}, 64'd0);
    check_eq("rst_pred_target", {32'd0, bpa.pred_target_o}, 64'd0);
    check_eq("rst_branch_cnt",  {48'd0, bpa.branch_cnt_o}, 64'd0);
    check_eq("rst_mispred_cnt", {48'd0, bpa.mispred_cnt_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // First allocation mispredicts, then hits with the new target
    apply(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t2_pred_taken",  {63'd0, bpa.pred_taken_o}, 64'd1);
    check_eq("t2_pred_target", {32'd0, bpa.pred_target_o}, 64'h80);
    check_eq("t2_mispred_cnt", {48'd0, bpa.mispred_cnt_o}, 64'd1);

    // Counter saturation both ways
    for (int k = 0; k < 5; k++)
      apply(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, m_pred(1'b1, 32'h40), 32'h80);
    for (int k = 0; k < 3; k++)
      apply(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h80, m_pred(1'b1, 32'h40), 32'h80);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t3_pred_after_nt", {63'd0, bpa.pred_taken_o}, 64'd0);

    // Aliasing entry replaces the old one
    apply(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t4_alias_miss", {63'd0, bpa.pred_taken_o}, 64'd0);
    apply(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t4_new_target", {32'd0, bpa.pred_target_o}, 64'h200);

    // Same-cycle lookup/update, then asynchronous reset between edges
    do_reset();
    apply(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t5_pred_next", {63'd0, bpa.pred_taken_o}, 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_pred",   {63'd0, bpa.pred_taken_o}, 64'd0);
    check_eq("t5_async_target", {32'd0, bpa.pred_target_o}, 64'd0);
    check_eq("t5_async_bcnt",   {48'd0, bpa.branch_cnt_o}, 64'd0);
    check_eq("t5_async_mcnt",   {48'd0, bpa.mispred_cnt_o}, 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;

    // Frozen when start_i is low
    apply(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    apply(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 32'h80);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t6_frozen_target", {32'd0, bpa.pred_target_o}, 64'h80);
    check_eq("t6_frozen_bcnt",   {48'd0, bpa.branch_cnt_o}, 64'd1);

    // 20 branches: the 4-bit statistics stop at 15
    do_reset();
    for (int k = 0; k < 20; k++)
      apply(1'b1, rnd_pc(), 1'b1, rnd_pc(), 1'($urandom_range(0, 1)), 32'h100, 1'b0, 32'h100);
    apply(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("t6_sat_b", {60'd0, bpb.branch_cnt_o}, 64'd15);
    check_eq("t6_cnt_a", {48'd0, bpa.branch_cnt_o}, 64'd20);

    // Randomized traffic over a small PC pool so hits, aliases and saturation all occur
    do_reset();
    for (int k = 0; k < 800; k++) begin
      st   = ($urandom_range(0, 9) != 0);
      uv   = ($urandom_range(0, 9) < 7);
      upc  = rnd_pc();
      tk   = 1'($urandom_range(0, 1));
      tgt  = 32'($urandom_range(1, 4)) << 8;
      pt   = ($urandom_range(0, 1) != 0) ? m_pred(1'b1, upc) : 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) != 0) ? tgt : (32'($urandom_range(1, 4)) << 8);
      apply(st, rnd_pc(), uv, upc, tk, tgt, pt, ptgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
